// File: rtl/fpu_trans_pkg.sv
// Shared definitions for the transcendental-unit scheduler: opcodes, the
// FP80 indefinite value, FSM state encodings and response status bits.
package fpu_trans_pkg;

    localparam logic [7:0] OP_FPTAN   = 8'h54;
    localparam logic [7:0] OP_FPATAN  = 8'h55;
    localparam logic [7:0] OP_F2XM1   = 8'h56;
    localparam logic [7:0] OP_FYL2X   = 8'h57;
    localparam logic [7:0] OP_FYL2XP1 = 8'h58;

    // Quiet NaN "real indefinite" returned when no real result exists
    localparam logic [79:0] FP_INDEFINITE = 80'hFFFF_C000_0000_0000_0000;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_ISSUE = 2'd1;
    localparam state_t S_WAIT  = 2'd2;
    localparam state_t S_RESP  = 2'd3;

    // Bit positions inside the 3-bit response status {illegal, timeout, error}
    localparam int STAT_ERROR   = 0;
    localparam int STAT_TIMEOUT = 1;
    localparam int STAT_ILLEGAL = 2;

    function automatic logic is_trans_op(input logic [7:0] op);
        return (op == OP_FPTAN)  || (op == OP_FPATAN) || (op == OP_F2XM1) ||
               (op == OP_FYL2X)  || (op == OP_FYL2XP1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after ptr (wrapping modulo N). The caller owns and advances the pointer.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] grant,
    output logic [1:0]   grant_idx
);

    logic found;

    // Scan positions ptr, ptr+1, ... and grant the first requester that is set
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && (j == (int'(ptr) + k) % N) && req[j]) begin
                    found     = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = 2'(j);
                end
            end
        end
    end

endmodule

// File: rtl/fpu_trans_scheduler.sv
// Shares one iterative transcendental engine among NUM_REQ requesters:
// round-robin accept, single-cycle start, watchdog-guarded wait for done,
// and a one-cycle response back to the requester that owned the operation.
module fpu_trans_scheduler
    import fpu_trans_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*8-1:0]  req_op,
    input  logic [NUM_REQ*80-1:0] req_a,
    input  logic [NUM_REQ*80-1:0] req_b,
    output logic                  unit_start,
    output logic [7:0]            unit_op,
    output logic [79:0]           unit_a,
    output logic [79:0]           unit_b,
    output logic                  unit_abort,
    input  logic                  unit_done,
    input  logic [79:0]           unit_res0,
    input  logic [79:0]           unit_res1,
    input  logic                  unit_error,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [79:0]           rsp_res0,
    output logic [79:0]           rsp_res1,
    output logic [2:0]            rsp_status,
    output logic                  busy,
    output logic [1:0]            owner
);

    localparam int             CW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]     LAST_REQ = 2'(NUM_REQ - 1);

    state_t               state;
    logic [1:0]           rr_ptr;
    logic [CW-1:0]        wd_cnt;
    logic [NUM_REQ-1:0]   grant;
    logic [1:0]           grant_idx;
    logic [7:0]           sel_op;
    logic [79:0]          sel_a;
    logic [79:0]          sel_b;
    logic                 accept;
    logic                 timeout_hit;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Route the granted requester's opcode and operands toward the latches
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op[8*i +: 8];
                sel_a  = req_a[80*i +: 80];
                sel_b  = req_b[80*i +: 80];
            end
        end
    end

    assign accept      = (state == S_IDLE) && (|grant);
    assign req_ready   = (state == S_IDLE) ? grant : '0;
    assign unit_start  = (state == S_ISSUE);
    assign busy        = (state != S_IDLE);
    // A done arriving in the last watchdog cycle takes priority over abort
    assign timeout_hit = (state == S_WAIT) && !unit_done && (wd_cnt >= CNT_LAST);
    assign unit_abort  = timeout_hit;

    // One-hot response strobe to whoever owns the finished operation
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (state == S_RESP) && (owner == 2'(i));
        end
    end

    // Main FSM: accept, issue, watchdog wait, respond; also holds all latches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            wd_cnt     <= '0;
            unit_op    <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            rsp_res0   <= '0;
            rsp_res1   <= '0;
            rsp_status <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        unit_op <= sel_op;
                        unit_a  <= sel_a;
                        unit_b  <= sel_b;
                        owner   <= grant_idx;
                        rr_ptr  <= (grant_idx == LAST_REQ) ? 2'd0 : grant_idx + 2'd1;
                        if (is_trans_op(sel_op)) begin
                            state <= S_ISSUE;
                        end else begin
                            rsp_res0   <= FP_INDEFINITE;
                            rsp_res1   <= FP_INDEFINITE;
                            rsp_status <= 3'(1 << STAT_ILLEGAL);
                            state      <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (unit_done) begin
                        rsp_res0   <= unit_res0;
                        rsp_res1   <= unit_res1;
                        rsp_status <= {2'b00, unit_error};
                        state      <= S_RESP;
                    end else if (timeout_hit) begin
                        rsp_res0   <= FP_INDEFINITE;
                        rsp_res1   <= FP_INDEFINITE;
                        rsp_status <= 3'(1 << STAT_TIMEOUT);
                        state      <= S_RESP;
                    end else if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_trans_scheduler.sv
// Self-checking bench for fpu_trans_scheduler: directed scenarios followed by
// randomized traffic, checked against a transaction-level rotation model and
// a behavioural model of the transcendental unit.
module tb_fpu_trans_scheduler;

    localparam int NR = 3;
    localparam int TO = 48;
    localparam logic [79:0] INDEF = 80'hFFFF_C000_0000_0000_0000;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*8-1:0]   req_op;
    logic [NR*80-1:0]  req_a;
    logic [NR*80-1:0]  req_b;
    logic              unit_start;
    logic [7:0]        unit_op;
    logic [79:0]       unit_a;
    logic [79:0]       unit_b;
    logic              unit_abort;
    logic              unit_done;
    logic [79:0]       unit_res0;
    logic [79:0]       unit_res1;
    logic              unit_error;
    logic [NR-1:0]     rsp_valid;
    logic [79:0]       rsp_res0;
    logic [79:0]       rsp_res1;
    logic [2:0]        rsp_status;
    logic              busy;
    logic [1:0]        owner;

    int total = 0;
    int bad = 0;
    int rrPtr = 0;
    int startCount = 0;
    int unitDelay = 0;
    logic [79:0] mRes0 = '0;
    logic [79:0] mRes1 = '0;
    logic        mErr = 1'b0;

    logic [7:0]  pOp [NR];
    logic [79:0] pA  [NR];
    logic [79:0] pB  [NR];

    fpu_trans_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .unit_start (unit_start),
        .unit_op    (unit_op),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_abort (unit_abort),
        .unit_done  (unit_done),
        .unit_res0  (unit_res0),
        .unit_res1  (unit_res1),
        .unit_error (unit_error),
        .rsp_valid  (rsp_valid),
        .rsp_res0   (rsp_res0),
        .rsp_res1   (rsp_res1),
        .rsp_status (rsp_status),
        .busy       (busy),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    // Engine model: after a start, pulse done in WAIT cycle unitDelay (0 = never)
    initial begin
        unit_done  = 1'b0;
        unit_res0  = '0;
        unit_res1  = '0;
        unit_error = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (unit_start === 1'b1) begin
                startCount++;
                if (unitDelay > 0) begin
                    for (int c = 1; c <= unitDelay; c++) begin
                        @(posedge clk);
                        #1;
                    end
                    unit_done  = 1'b1;
                    unit_res0  = mRes0;
                    unit_res1  = mRes1;
                    unit_error = mErr;
                    @(posedge clk);
                    #1;
                    unit_done  = 1'b0;
                    unit_res0  = '0;
                    unit_res1  = '0;
                    unit_error = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [79:0] rand80();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[79:0];
    endfunction

    // Rotation rule: first pending requester at or after the pointer, wrapping
    function automatic int expGrant(input logic [NR-1:0] pend, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (pend[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return 0;
    endfunction

    task automatic applyStimulus(input int i, input logic [7:0] op, input logic [79:0] a, input logic [79:0] b);
        pOp[i] = op;
        pA[i]  = a;
        pB[i]  = b;
        req_op[8*i +: 8]   = op;
        req_a[80*i +: 80]  = a;
        req_b[80*i +: 80]  = b;
        req_valid[i]       = 1'b1;
    endtask

    task automatic raiseRandom(input int i);
        logic [7:0] op;
        if ($urandom_range(0, 5) == 0) begin
            op = 8'($urandom_range(0, 255));
            if (op >= 8'h54 && op <= 8'h58) op = 8'hA0;
        end else begin
            op = 8'(8'h54 + $urandom_range(0, 4));
        end
        applyStimulus(i, op, rand80(), rand80());
    endtask

    // One full transaction for requester r, expected to win the current arbitration
    task automatic doTransaction(input int r, input int delay, input logic [79:0] r0,
                                 input logic [79:0] r1, input logic err);
        logic [NR-1:0] expReady;
        logic [79:0]   e0;
        logic [79:0]   e1;
        logic [2:0]    es;
        logic          legal;
        int            startsBefore;
        int            cyc;
        int            expLat;
        int            abortAt;
        int            expAbort;
        int            aborts;
        expReady = '0;
        expReady[r] = 1'b1;
        legal = (pOp[r] >= 8'h54) && (pOp[r] <= 8'h58);
        #1;
        checkOutput("idle_busy", 80'(busy), 80'(0));
        checkOutput("req_ready", 80'(req_ready), 80'(expReady));
        unitDelay = delay;
        mRes0 = r0;
        mRes1 = r1;
        mErr = err;
        startsBefore = startCount;
        tick();
        req_valid[r] = 1'b0;
        rrPtr = (r + 1) % NR;
        checkOutput("owner", 80'(owner), 80'(r));
        checkOutput("ready_off", 80'(req_ready), 80'(0));
        if (legal) begin
            if (delay >= 1 && delay <= TO) begin
                expLat = delay + 1; expAbort = -1; e0 = r0; e1 = r1; es = {2'b00, err};
            end else begin
                expLat = TO + 1; expAbort = TO; e0 = INDEF; e1 = INDEF; es = 3'b010;
            end
            checkOutput("unit_start", 80'(unit_start), 80'(1));
            checkOutput("start_count", 80'(startCount - startsBefore), 80'(1));
            checkOutput("unit_op", 80'(unit_op), 80'(pOp[r]));
            checkOutput("unit_a", unit_a, pA[r]);
            checkOutput("unit_b", unit_b, pB[r]);
            cyc = 0; abortAt = -1; aborts = 0;
            while (rsp_valid == '0 && cyc < TO + 20) begin
                tick();
                cyc++;
                if (unit_abort === 1'b1) begin
                    aborts++;
                    abortAt = cyc;
                end
            end
            checkOutput("latency", 80'(cyc), 80'(expLat));
            checkOutput("abort_cycle", 80'(abortAt), 80'(expAbort));
            checkOutput("abort_count", 80'(aborts), 80'((expAbort > 0) ? 1 : 0));
            checkOutput("op_stable", 80'(unit_op), 80'(pOp[r]));
        end else begin
            e0 = INDEF; e1 = INDEF; es = 3'b100;
            checkOutput("no_start", 80'(unit_start), 80'(0));
        end
        checkOutput("rsp_valid", 80'(rsp_valid), 80'(expReady));
        checkOutput("rsp_res0", rsp_res0, e0);
        checkOutput("rsp_res1", rsp_res1, e1);
        checkOutput("rsp_status", 80'(rsp_status), 80'(es));
        tick();
        checkOutput("rsp_pulse", 80'(rsp_valid), 80'(0));
        checkOutput("status_hold", 80'(rsp_status), 80'(es));
        checkOutput("res0_hold", rsp_res0, e0);
        if (!legal) checkOutput("illegal_nostart", 80'(startCount - startsBefore), 80'(0));
    endtask

    initial begin
        int g;
        int d;
        reset_n   = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NR; i++) begin
            pOp[i] = '0; pA[i] = '0; pB[i] = '0;
        end
        $display("[TB] reset phase");
        repeat (3) tick();
        checkOutput("rst_busy", 80'(busy), 80'(0));
        checkOutput("rst_start", 80'(unit_start), 80'(0));
        checkOutput("rst_rsp_valid", 80'(rsp_valid), 80'(0));
        checkOutput("rst_owner", 80'(owner), 80'(0));
        checkOutput("rst_status", 80'(rsp_status), 80'(0));
        checkOutput("rst_unit_op", 80'(unit_op), 80'(0));
        reset_n = 1'b1;
        tick();
        checkOutput("post_rst_ready", 80'(req_ready), 80'(0));

        $display("[TB] single FPTAN");
        applyStimulus(0, 8'h54, 80'h3FFE_C90F_DAA2_2168_C235, 80'h0);
        doTransaction(expGrant(req_valid, rrPtr), 40, 80'h3FFF_8000_0000_0000_0000,
                      80'h3FFF_8000_0000_0000_0000, 1'b0);

        $display("[TB] contention req0/req1");
        applyStimulus(0, 8'h55, 80'h1111, 80'h2222);
        applyStimulus(1, 8'h56, 80'h3333, 80'h4444);
        for (int n = 0; n < 4; n++) begin
            g = expGrant(req_valid, rrPtr);
            doTransaction(g, 3 + n, rand80(), rand80(), 1'b0);
            applyStimulus(g, pOp[g], pA[g], pB[g]);
        end
        req_valid = '0;

        $display("[TB] illegal opcode");
        applyStimulus(1, 8'h20, 80'h5, 80'h6);
        doTransaction(expGrant(req_valid, rrPtr), 0, '0, '0, 1'b0);

        $display("[TB] watchdog timeout then new request");
        applyStimulus(0, 8'h55, 80'h77, 80'h88);
        doTransaction(expGrant(req_valid, rrPtr), 0, '0, '0, 1'b0);
        applyStimulus(1, 8'h56, 80'h99, 80'hAA);
        doTransaction(expGrant(req_valid, rrPtr), 2, 80'hABC, 80'hDEF, 1'b0);

        $display("[TB] done on final watchdog cycle");
        applyStimulus(2, 8'h58, 80'h123, 80'h456);
        doTransaction(expGrant(req_valid, rrPtr), TO, 80'hCAFE, 80'hBEEF, 1'b1);

        $display("[TB] reset during WAIT");
        applyStimulus(0, 8'h57, 80'hAAAA, 80'hBBBB);
        unitDelay = 0;
        tick();
        req_valid = '0;
        tick();
        tick();
        checkOutput("in_wait_busy", 80'(busy), 80'(1));
        reset_n = 1'b0;
        #1;
        checkOutput("async_busy", 80'(busy), 80'(0));
        checkOutput("async_owner", 80'(owner), 80'(0));
        checkOutput("async_unit_op", 80'(unit_op), 80'(0));
        checkOutput("async_unit_a", unit_a, 80'(0));
        checkOutput("async_res0", rsp_res0, 80'(0));
        checkOutput("async_status", 80'(rsp_status), 80'(0));
        checkOutput("async_abort", 80'(unit_abort), 80'(0));
        for (int n = 0; n < 3; n++) begin
            tick();
            checkOutput("rst_no_rsp", 80'(rsp_valid), 80'(0));
        end
        reset_n = 1'b1;
        rrPtr = 0;
        tick();
        applyStimulus(0, 8'h57, 80'h4000_8000_0000_0000_0000, 80'h3FFF_8000_0000_0000_0000);
        doTransaction(expGrant(req_valid, rrPtr), 5, 80'h1234_5678, 80'h0, 1'b0);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) raiseRandom(i);
            end
            if (req_valid == '0) raiseRandom(int'($urandom_range(0, NR - 1)));
            g = expGrant(req_valid, rrPtr);
            d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 10));
            doTransaction(g, d, rand80(), rand80(), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_trans_scheduler.md
# fpu_trans_scheduler

Scheduler that shares one iterative transcendental unit (FPTAN/FPATAN/F2XM1/FYL2X/FYL2XP1 engine) among several requesters, e.g. the FPU_Core instruction path and the microcode sequencer. It round-robin arbitrates requests and latches operands. It issues a single-cycle start to the unit and waits for done under a watchdog. It routes the results back to the owning requester with status flags.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- TIMEOUT_CYCLES, 10000, watchdog limit in WAIT state
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant; transfer on valid&ready
- req_op  in  NUM_REQ*8  opcode, slice i = [8i+7:8i]
- req_a  in  NUM_REQ*80  ST(0) operand (FP80)
- req_b  in  NUM_REQ*80  ST(1) operand (FP80)
- unit_start  out  1  one-cycle start pulse
- unit_op  out  8  latched opcode, stable from start until done
- unit_a, unit_b  out  80  latched operands, stable from start until done
- unit_abort  out  1  one-cycle pulse on timeout
- unit_done  in  1  result valid pulse
- unit_res0, unit_res1  in  80  results (res1 used by FPTAN push)
- unit_error  in  1  exception flag, sampled with done
- rsp_valid  out  NUM_REQ  one-cycle, one-hot to owner
- rsp_res0, rsp_res1  out  80  registered results
- rsp_status  out  3  {illegal, timeout, error}
- busy  out  1  state != IDLE
- owner  out  2  index of current/last grantee

## Operation
- Legal opcodes: 0x54 FPTAN, 0x55 FPATAN, 0x56 F2XM1, 0x57 FYL2X, 0x58 FYL2XP1.
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready is asserted combinationally to the first requester with req_valid set. The search starts at rr_ptr and wraps modulo NUM_REQ. On transfer the block latches op/a/b and owner, and sets rr_ptr = owner+1 (wrapping).
  - Legal op: next state ISSUE.
  - Illegal op: next state RESP with status 100 and both results FP_INDEFINITE (80'hFFFF_C000000000000000). The unit is never started.
- ISSUE: unit_start=1 for exactly one cycle; the watchdog counter clears to 0; next state WAIT.
- WAIT: the counter increments each cycle.
  - unit_done: capture res0/res1/error; status = {0,0,unit_error}; next state RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without done: unit_abort=1; status 010; results FP_INDEFINITE; next state RESP.
  - If done and timeout fall in the same cycle, done wins and there is no abort.
- RESP: rsp_valid[owner]=1 for one cycle; next state IDLE.
- rsp_res*/rsp_status hold their values until the next RESP.
- unit_done outside WAIT is ignored.
- req_ready is 0 in every state except IDLE.
- Counter width is clog2(TIMEOUT_CYCLES)+1; it saturates and never wraps.
- Reset value of every output is 0, except owner=0 and rr_ptr=0. Reset puts the FSM in IDLE.
- Reset mid-operation drops the transaction with no response. The unit shares reset_n.

## Timing
- Request accepted at edge T: unit_start high in cycle T+1. WAIT begins at T+2.
- unit_done in cycle D: rsp_valid in cycle D+1. The earliest next accept is cycle D+2.
- An illegal opcode accepted at T gives rsp_valid at T+1.
- Minimum legal latency from accept to rsp_valid is 3 cycles, with done in the first WAIT cycle.
- Back-to-back requests from all requesters are served in strict rotation. There is no starvation; worst-case wait is (NUM_REQ-1) full transactions.
- Requesters must hold req_valid/op/a/b stable until req_ready is seen.

## Structure
- Package fpu_trans_pkg holds:
  - opcode localparams (0x54..0x58)
  - FP_INDEFINITE
  - state enum
  - status bit indices
  - an is_trans_op() function
- Sub-module rr_arbiter (parameter N) handles the arbitration: it takes req vector and ptr and returns a one-hot grant plus a grant index. It is purely combinational. The scheduler owns the pointer register.
- Scheduler core target size is about 200 lines of RTL.

## Test plan
- Single FPTAN: req0 op 0x54, a=0x3FFE_C90FDAA22168C235, unit model done after 40 cycles with res0=res1=0x3FFF_8000000000000000 -> unit_start 1 cycle after accept; rsp_valid=01 41 cycles after start; status 000.
- Contention: req0 and req1 both valid continuously, rr_ptr=0 -> grants alternate 0,1,0,1. Each response goes only to its owner.
- Illegal op 0x20 from req1 -> no unit_start; rsp_valid=10 next cycle; status 100; res0=res1=0xFFFF_C000000000000000.
- Timeout: TIMEOUT_CYCLES=16, unit never done -> unit_abort pulse in WAIT cycle 16; rsp status 010 with indefinite results; then a new request is accepted.
- Done coinciding with the final timeout cycle (unit_error=1) -> no abort; status 001; unit results returned.
- reset_n asserted low in WAIT -> all outputs 0 asynchronously, no rsp_valid; after release, req0 FYL2X completes normally.
